serial_subtractor_16bit: RTL and testbench

- Bit-serial multi-cycle subtractor: the inverse companion to the team's 16-bit ripple adder.
- Computes diff = a - b - borrow_in (unsigned, mod 2^NUM_BITS), one bit per clock, LSB first, through a single 1-bit full-subtractor cell.
- Reports final borrow-out as underflow.
- Used where area matters more than latency, and as a cross-check engine against the combinational adder (a + b + cin vs. sum - b).

---
 rtl/serial_subtractor_16bit.sv | 116 +++++++++++
 tb/tb_serial_subtractor_16bit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_16bit.sv
// Bit-serial subtractor: diff = a - b - borrow_in (mod 2^NUM_BITS), one bit
// per clock, LSB first, through a single full-subtractor cell. The final
// borrow-out is reported as underflow.
//
// state | meaning
// IDLE  | waiting for start; operands captured on an accepted start
// SHIFT | one difference bit produced per cycle, NUM_BITS cycles
// DONE  | result registered, done pulses for this single cycle
module serial_subtractor_16bit #(
    parameter int NUM_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                borrow_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] diff,
    output logic                underflow
);

    localparam int CW = $clog2(NUM_BITS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       count;
    logic [NUM_BITS-1:0] a_sr;
    logic [NUM_BITS-1:0] b_sr;
    logic [NUM_BITS-1:0] d_sr;
    logic                brw;
    logic                d_bit;
    logic                brw_next;
    logic                last_bit;

    // Full-subtractor cell on the current LSBs plus the running borrow.
    always_comb begin
        d_bit    = a_sr[0] ^ b_sr[0] ^ brw;
        brw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
        last_bit = (count == CW'(NUM_BITS - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, bit-serial shifting and result registration.
    // The result is loaded on the final shift edge from the fully shifted
    // value, so diff/underflow change exactly when done rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            d_sr      <= '0;
            brw       <= 1'b0;
            diff      <= '0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= borrow_in;
                        d_sr  <= '0;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    a_sr  <= {1'b0, a_sr[NUM_BITS-1:1]};
                    b_sr  <= {1'b0, b_sr[NUM_BITS-1:1]};
                    d_sr  <= {d_bit, d_sr[NUM_BITS-1:1]};
                    brw   <= brw_next;
                    count <= count + CW'(1);
                    if (last_bit) begin
                        diff      <= {d_bit, d_sr[NUM_BITS-1:1]};
                        underflow <= brw_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Testbench for serial_subtractor_16bit: directed scenarios followed by
// randomized operations against an arithmetic reference model.
module tb_serial_subtractor_16bit;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         underflow;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt = 0;
    int exp_done = 0;

    serial_subtractor_16bit #(.NUM_BITS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .borrow_in (borrow_in),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [N:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                         input logic mbin);
        return {1'b0, ma} - {1'b0, mb} - {{N{1'b0}}, mbin};
    endfunction

    // One complete operation; inj_at >= 1 drives a stray start (a=5, b=9)
    // at that cycle of the shift phase, which must be ignored.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                          input logic tbin, input logic [N-1:0] exp_diff,
                          input logic exp_uf, input string tag, input int inj_at);
        logic [N-1:0] prev_diff;
        logic         prev_uf;
        logic         held_bad;
        int           edges;
        int           busy_cycles;
        prev_diff = diff;
        prev_uf   = underflow;
        held_bad  = 1'b0;
        a = ta; b = tb_; borrow_in = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_done++;
        edges = 1;
        busy_cycles = 0;
        a = N'($urandom()); b = N'($urandom()); borrow_in = 1'($urandom());
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_cycles++;
            if (diff !== prev_diff || underflow !== prev_uf) held_bad = 1'b1;
            if (edges == inj_at) begin
                start = 1'b1; a = 16'd5; b = 16'd9; borrow_in = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        chk({tag, ".done_seen"}, 32'(done), 32'd1);
        chk({tag, ".latency_edges"}, 32'(edges), 32'(N + 1));
        chk({tag, ".busy_cycles"}, 32'(busy_cycles), 32'(N));
        chk({tag, ".diff"}, 32'(diff), 32'(exp_diff));
        chk({tag, ".underflow"}, 32'(underflow), 32'(exp_uf));
        chk({tag, ".held_mid_op"}, 32'(held_bad), 32'd0);
        @(negedge clk);
        chk({tag, ".done_pulse_end"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [N:0]   exp;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rbin;
        int           cyc;
        int           idle;
        int           dc0;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.diff", 32'(diff), 32'd0);
        chk("reset.underflow", 32'(underflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: all-ones wrap with borrow_in
        run_op(16'd0, 16'd0, 1'b1, 16'hFFFF, 1'b1, "t1", -1);

        // 2: ordinary subtraction, then equal operands with borrow
        run_op(16'd12000, 16'd1, 1'b1, 16'd11998, 1'b0, "t2a", -1);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "t2b", -1);

        // 3: stray start at shift cycle 5 is ignored
        run_op(16'd13456, 16'd1, 1'b0, 16'd13455, 1'b0, "t3", 5);

        // 4: reset mid-shift aborts the op and clears the result
        dc0 = done_cnt;
        a = 16'h8000; b = 16'h0001; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4.busy_after_rst", 32'(busy), 32'd0);
        chk("t4.diff_after_rst", 32'(diff), 32'd0);
        chk("t4.uf_after_rst", 32'(underflow), 32'd0);
        repeat (25) @(negedge clk);
        chk("t4.no_done", 32'(done_cnt - dc0), 32'd0);
        run_op(16'd10, 16'd10, 1'b0, 16'd0, 1'b0, "t4b", -1);

        // 5: start held high gives back-to-back ops with one IDLE cycle
        a = 16'hFFFF; b = 16'h0000; borrow_in = 1'b0; start = 1'b1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        exp_done++;
        chk("t5a.done_seen", 32'(done), 32'd1);
        chk("t5a.diff", 32'(diff), 32'hFFFF);
        chk("t5a.underflow", 32'(underflow), 32'd0);
        a = 16'h0000; b = 16'hFFFF;
        exp_done++;
        cyc = 0;
        idle = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b0 && done === 1'b0) idle++;
        end while (done !== 1'b1 && cyc < 40);
        start = 1'b0;
        chk("t5b.done_to_done", 32'(cyc), 32'd18);
        chk("t5b.idle_cycles", 32'(idle), 32'd1);
        chk("t5b.diff", 32'(diff), 32'h0001);
        chk("t5b.underflow", 32'(underflow), 32'd1);
        @(negedge clk);

        // 6: randomized operations against the arithmetic model
        for (int i = 0; i < 1000; i++) begin
            ra   = N'($urandom());
            rb   = N'($urandom());
            rbin = 1'($urandom());
            if (i % 8 == 0) rb = ra;
            exp  = model(ra, rb, rbin);
            run_op(ra, rb, rbin, exp[N-1:0], exp[N], "rand", -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("done_count", 32'(done_cnt), 32'(exp_done));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
